mem_stage: RTL

Memory-access stage of the five-stage MIPS pipeline, directly downstream of the execute stage. It registers `ex_to_mem_bus`, captures the synchronous data-SRAM read word, and holds that word across downstream stalls. It aligns and extends load data, then selects the register write-back value. It drives `mem_to_wb_bus` to write-back and `mem_to_rf_bus` to the decode-stage forwarding network.

---
 rtl/mem_stage_pkg.sv | 38 +++
 rtl/mem_stage_load_align.sv | 42 ++++
 rtl/mem_stage.sv | 76 +++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared widths, bus layout and capture states for the memory stage
package mem_stage_pkg;

    localparam int EX_TO_MEM_WD = 151;
    localparam int MEM_TO_WB_WD = 136;
    localparam int MEM_TO_RF_WD = 104;
    localparam int HILO_WD      = 66;
    localparam int STALL_BUS_WD = 6;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // Bit positions inside mem_op
    localparam int OP_LB  = 7;
    localparam int OP_LBU = 6;
    localparam int OP_LH  = 5;
    localparam int OP_LHU = 4;
    localparam int OP_LW  = 3;

    typedef enum logic {
        CAP_HELD  = 1'b0,
        CAP_FRESH = 1'b1
    } cap_state_e;

    typedef struct packed {
        logic [7:0]         mem_op;
        logic [HILO_WD-1:0] hilo_bus;
        logic [31:0]        pc;
        logic               data_ram_en;
        logic               data_ram_wen;
        logic [3:0]         data_ram_sel;
        logic               sel_rf_res;
        logic               rf_we;
        logic [4:0]         rf_waddr;
        logic [31:0]        ex_result;
    } ex_to_mem_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// rtl/mem_stage_load_align.sv - little-endian byte/half/word selection and extension of load data
module load_align
    import mem_stage_pkg::*;
(
    input  logic [7:0]  mem_op,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        unused_op_bits;

    assign unused_op_bits = ^mem_op[2:0];

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        // Halfword picks by addr[1] only; misaligned halves are not trapped
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

        data = '0;
        if (mem_op[OP_LB])
            data = {{24{byte_sel[7]}}, byte_sel};
        else if (mem_op[OP_LBU])
            data = {24'd0, byte_sel};
        else if (mem_op[OP_LH])
            data = {{16{half_sel[15]}}, half_sel};
        else if (mem_op[OP_LHU])
            data = {16'd0, half_sel};
        else if (mem_op[OP_LW])
            data = rdata;
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage with SRAM read-word capture across stalls
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [STALL_BUS_WD-1:0]  stall,
    input  logic [EX_TO_MEM_WD-1:0]  ex_to_mem_bus,
    input  logic [31:0]              data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0]  mem_to_wb_bus,
    output logic [MEM_TO_RF_WD-1:0]  mem_to_rf_bus
);

    ex_to_mem_t ex_to_mem_bus_r;
    cap_state_e state, state_next;
    logic [31:0] rdata_buf;
    logic [31:0] rdata_eff;
    logic [31:0] load_data;
    logic [31:0] rf_wdata;
    logic        load_en;
    logic        bubble;
    logic        unused_bits;

    assign load_en = (stall[3] == NO_STOP);
    assign bubble  = (stall[3] == STOP) && (stall[4] == NO_STOP);

    always_ff @(posedge clk) begin
        if (rst)
            ex_to_mem_bus_r <= '0;
        else if (bubble)
            ex_to_mem_bus_r <= '0;
        else if (load_en)
            ex_to_mem_bus_r <= ex_to_mem_bus;
    end

    // The SRAM word is only valid the cycle after a fresh load; afterwards we replay the buffer
    always_comb begin
        state_next = CAP_HELD;
        if (!rst && load_en)
            state_next = CAP_FRESH;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= CAP_HELD;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst)
            rdata_buf <= '0;
        else if (state == CAP_FRESH)
            rdata_buf <= data_sram_rdata;
    end

    assign rdata_eff = (state == CAP_FRESH) ? data_sram_rdata : rdata_buf;

    load_align u_load_align (
        .mem_op (ex_to_mem_bus_r.mem_op),
        .addr   (ex_to_mem_bus_r.ex_result[1:0]),
        .rdata  (rdata_eff),
        .data   (load_data)
    );

    assign rf_wdata = ex_to_mem_bus_r.sel_rf_res ? load_data : ex_to_mem_bus_r.ex_result;

    assign mem_to_wb_bus = {ex_to_mem_bus_r.hilo_bus, ex_to_mem_bus_r.pc,
                            ex_to_mem_bus_r.rf_we, ex_to_mem_bus_r.rf_waddr, rf_wdata};
    assign mem_to_rf_bus = {ex_to_mem_bus_r.hilo_bus,
                            ex_to_mem_bus_r.rf_we, ex_to_mem_bus_r.rf_waddr, rf_wdata};

    assign unused_bits = ^{stall[5], stall[2:0], ex_to_mem_bus_r.data_ram_en,
                           ex_to_mem_bus_r.data_ram_wen, ex_to_mem_bus_r.data_ram_sel};

endmodule
